// File: rtl/fft_pkg.sv
// Shared types and constants for the 64-point FFT frame sequencer.
package fft_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } fft_seq_state_t;

    localparam int FFT_N               = 64;
    localparam int FFT_LOG2_N          = 6;
    localparam int FFT_CORE_CYCLES_DEF = 200;

endpackage

// File: rtl/fft_run_counter.sv
// Loadable down-counter that times the FFT core's butterfly schedule.
// clr wins over load, load wins over dec; zero flags a terminal count.
module fft_run_counter #(
    parameter int CNT_W = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic [CNT_W-1:0] count,
    output logic             zero
);

    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (load) begin
            count_d = load_val;
        end else if (dec && count_q != '0) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
    assign zero  = (count_q == '0);

endmodule

// File: rtl/fft_frame_sequencer.sv
// Frame-level controller for the 64-point in-place FFT core.
// Optional 16-bit completed-frame counter enabled by FFT_SEQ_FRAME_CNT_EN.
module fft_frame_sequencer
    import fft_pkg::*;
#(
    parameter int N_POINTS    = FFT_N,
    parameter int CORE_CYCLES = FFT_CORE_CYCLES_DEF,
    parameter int CNT_W       = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        core_start,
    output logic        busy,
    output logic        out_valid,
    input  logic        out_ready
`ifdef FFT_SEQ_FRAME_CNT_EN
    ,
    output logic [15:0] frame_count
`endif
);

    // Reject configurations the core or the run counter cannot honour.
    if (N_POINTS != FFT_N || CORE_CYCLES < 1 || CORE_CYCLES > 1023 ||
        (CORE_CYCLES - 1) >= (2 ** CNT_W)) begin : g_bad_param
        $error("fft_frame_sequencer: illegal parameter set");
    end

    localparam logic [CNT_W-1:0] RUN_LOAD = CNT_W'(CORE_CYCLES - 1);

    fft_seq_state_t   state_q, state_d;
    logic             cnt_clr, cnt_load, cnt_dec, cnt_zero;
    logic [CNT_W-1:0] cnt_val;

    fft_run_counter #(.CNT_W(CNT_W)) u_run_counter (
        .clk      (clk),
        .rst      (rst),
        .clr      (cnt_clr),
        .load     (cnt_load),
        .load_val (RUN_LOAD),
        .dec      (cnt_dec),
        .count    (cnt_val),
        .zero     (cnt_zero)
    );

    always_comb begin
        state_d  = state_q;
        cnt_clr  = 1'b0;
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;
        if (flush) begin
            state_d = IDLE;
            cnt_clr = 1'b1;
        end else begin
            unique case (state_q)
                IDLE:  if (in_valid) state_d = START;
                START: begin
                    state_d  = RUN;
                    cnt_load = 1'b1;
                end
                RUN: begin
                    if (cnt_zero) state_d = DONE;
                    else          cnt_dec = 1'b1;
                end
                DONE:  if (out_ready) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    assign in_ready   = (state_q == IDLE);
    assign core_start = (state_q == START);
    assign busy       = (state_q == START) || (state_q == RUN);
    assign out_valid  = (state_q == DONE);

`ifdef FFT_SEQ_FRAME_CNT_EN
    logic [15:0] frame_count_q, frame_count_d;

    // Survives flush; only a clean output handshake counts.
    always_comb begin
        frame_count_d = frame_count_q;
        if (state_q == DONE && out_ready && !flush && frame_count_q != 16'hFFFF) begin
            frame_count_d = frame_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            frame_count_q <= '0;
        end else begin
            frame_count_q <= frame_count_d;
        end
    end

    assign frame_count = frame_count_q;
`else
    logic unused_cnt;
    assign unused_cnt = ^cnt_val;
`endif

endmodule

// File: tb/tb_fft_frame_sequencer.sv
// Directed plus randomized checks of fft_frame_sequencer against a
// timeline model: each frame is tracked by its accept edge only.
module tb_fft_frame_sequencer;

    localparam int CC = 200;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic        in_ready, core_start, busy, out_valid;
`ifdef FFT_SEQ_FRAME_CNT_EN
    logic [15:0] frame_count;
`endif

    fft_frame_sequencer #(.N_POINTS(64), .CORE_CYCLES(CC), .CNT_W(10)) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .core_start (core_start),
        .busy       (busy),
        .out_valid  (out_valid),
        .out_ready  (out_ready)
`ifdef FFT_SEQ_FRAME_CNT_EN
        ,
        .frame_count(frame_count)
`endif
    );

    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_err = 0;
    bit          have_f = 1'b0;
    int          acc_e = 0;
    int          e_now = 0;
    logic [15:0] m_cnt = 16'd0;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int age();
        return e_now - acc_e;
    endfunction

    task automatic check_all();
        logic e_ir, e_cs, e_bz, e_ov;
        e_ir = !have_f;
        e_cs = have_f && age() == 0;
        e_bz = have_f && age() <= CC;
        e_ov = have_f && age() >= CC + 1;
        chk("in_ready",   {15'd0, in_ready},   {15'd0, e_ir});
        chk("core_start", {15'd0, core_start}, {15'd0, e_cs});
        chk("busy",       {15'd0, busy},       {15'd0, e_bz});
        chk("out_valid",  {15'd0, out_valid},  {15'd0, e_ov});
`ifdef FFT_SEQ_FRAME_CNT_EN
        chk("frame_count", frame_count, m_cnt);
`endif
    endtask

    // Advance one clock: apply the frame rules to the inputs present at the edge.
    task automatic step();
        @(posedge clk);
        e_now++;
        if (flush) begin
            have_f = 1'b0;
        end else if (!have_f) begin
            if (in_valid) begin
                have_f = 1'b1;
                acc_e  = e_now;
            end
        end else if (age() >= CC + 2 && out_ready) begin
            have_f = 1'b0;
            if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
        end
        #1;
        check_all();
    endtask

    initial begin
        // Reset held: outputs at reset values without any clock edge.
        #2;
        check_all();
        #1 rst = 1'b1;
        for (int i = 0; i < 4; i++) step();

        // Single frame followed by 50 cycles of backpressure with stray offers.
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < CC + 1; i++) step();
        chk("single_out_valid_at_k201", {15'd0, out_valid}, 16'd1);
        for (int i = 0; i < 50; i++) begin
            in_valid = 1'($urandom_range(0, 1));
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("handshake_idle", {15'd0, in_ready}, 16'd1);

        // Flush in RUN when the run counter reads 100.
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 300 && age() < 100; i++) step();
        chk("flush_run_age", 16'(age()), 16'd100);
        flush = 1'b1;
        step();
        flush = 1'b0;
        for (int i = 0; i < CC + 5; i++) step();

        // Flush together with out_ready while DONE: no handshake counted.
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < CC + 1; i++) step();
        flush     = 1'b1;
        out_ready = 1'b1;
        step();
        flush     = 1'b0;
        out_ready = 1'b0;
        step();

        // Back-to-back with in_valid and out_ready tied high.
        in_valid  = 1'b1;
        out_ready = 1'b1;
        begin
            int starts = 0;
            for (int i = 0; i < 5 * (CC + 3); i++) begin
                step();
                if (core_start) starts++;
            end
            chk("b2b_starts", 16'(starts), 16'd5);
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        for (int i = 0; i < CC + 3; i++) step();

        // Asynchronous reset between edges in the middle of RUN.
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 60; i++) step();
        #2 rst = 1'b0;
        #1;
        have_f = 1'b0;
        m_cnt  = 16'd0;
        check_all();
        #2 rst = 1'b1;
        for (int i = 0; i < 3; i++) step();

`ifdef FFT_SEQ_FRAME_CNT_EN
        // Counter saturation from a forced full value.
        force dut.frame_count_q = 16'hFFFF;
        #1 release dut.frame_count_q;
        m_cnt = 16'hFFFF;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < CC + 1; i++) step();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        step();
        chk("frame_count_sat", frame_count, 16'hFFFF);
`endif

        // Randomized traffic.
        for (int i = 0; i < 2500; i++) begin
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 3) == 0);
            flush     = ($urandom_range(0, 199) == 0);
            step();
        end
        flush = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
